// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port 32-word data RAM: round-robin with an
// atomic lock for read-modify-write. Define DMEM_ARB_CPU_PRIO_EN for fixed port-0 priority.
module dmem_arbiter #(
    parameter int DATA_W     = 32,
    parameter int DEPTH_LOG2 = 5
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req0,
    input  logic                  we0,
    input  logic                  lock0,
    input  logic [31:0]           addr0,
    input  logic [DATA_W-1:0]     wdata0,
    output logic                  gnt0,
    output logic                  rvalid0,
    output logic [DATA_W-1:0]     rdata0,
    input  logic                  req1,
    input  logic                  we1,
    input  logic                  lock1,
    input  logic [31:0]           addr1,
    input  logic [DATA_W-1:0]     wdata1,
    output logic                  gnt1,
    output logic                  rvalid1,
    output logic [DATA_W-1:0]     rdata1,
    output logic                  mem_we,
    output logic [DEPTH_LOG2-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic                  err
);

    logic                  last_grant_q, last_grant_d;
    logic                  owner_locked_q, owner_locked_d;
    logic                  rsp_pending_q, rsp_pending_d;
    logic                  rsp_port_q, rsp_port_d;
    logic                  err_q, err_d;
    logic [DEPTH_LOG2-1:0] addr_hold_q, addr_hold_d;
    logic [DATA_W-1:0]     din_hold_q, din_hold_d;

    logic                  grant_any;
    logic                  grant_port;
    logic                  owner_lock;
    logic                  lock_hold;
    logic                  sel_we;
    logic                  sel_lock;
    logic [31:0]           sel_addr;
    logic [DATA_W-1:0]     sel_wdata;
    logic                  addr_lsb_unused;

    // The lock only holds while the owner still asserts its lock line.
    assign owner_lock = last_grant_q ? lock1 : lock0;
    assign lock_hold  = owner_locked_q & owner_lock;

    always_comb begin
        grant_any  = 1'b0;
        grant_port = 1'b0;
        if (req0 && req1) begin
            grant_any = 1'b1;
`ifdef DMEM_ARB_CPU_PRIO_EN
            grant_port = 1'b0;
`else
            grant_port = lock_hold ? last_grant_q : ~last_grant_q;
`endif
        end else if (req0) begin
            grant_any  = 1'b1;
            grant_port = 1'b0;
        end else if (req1) begin
            grant_any  = 1'b1;
            grant_port = 1'b1;
        end
        if (!resetn) begin
            grant_any = 1'b0;
        end
    end

    assign sel_we          = grant_port ? we1    : we0;
    assign sel_lock        = grant_port ? lock1  : lock0;
    assign sel_addr        = grant_port ? addr1  : addr0;
    assign sel_wdata       = grant_port ? wdata1 : wdata0;
    assign addr_lsb_unused = ^sel_addr[1:0];

    assign gnt0     = grant_any & ~grant_port;
    assign gnt1     = grant_any & grant_port;
    assign mem_we   = grant_any & sel_we;
    assign mem_addr = grant_any ? sel_addr[DEPTH_LOG2+1:2] : addr_hold_q;
    assign mem_din  = grant_any ? sel_wdata : din_hold_q;

    always_comb begin
        last_grant_d   = last_grant_q;
        owner_locked_d = owner_locked_q;
        rsp_pending_d  = 1'b0;
        rsp_port_d     = rsp_port_q;
        err_d          = err_q;
        addr_hold_d    = addr_hold_q;
        din_hold_d     = din_hold_q;
        if (grant_any) begin
            last_grant_d   = grant_port;
            owner_locked_d = sel_lock;
            rsp_pending_d  = ~sel_we;
            rsp_port_d     = grant_port;
            err_d          = err_q | (|sel_addr[31:DEPTH_LOG2+2]);
            addr_hold_d    = sel_addr[DEPTH_LOG2+1:2];
            din_hold_d     = sel_wdata;
        end else if (!owner_lock) begin
            owner_locked_d = 1'b0;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            last_grant_q   <= 1'b1;
            owner_locked_q <= 1'b0;
            rsp_pending_q  <= 1'b0;
            rsp_port_q     <= 1'b0;
            err_q          <= 1'b0;
            addr_hold_q    <= '0;
            din_hold_q     <= '0;
        end else begin
            last_grant_q   <= last_grant_d;
            owner_locked_q <= owner_locked_d;
            rsp_pending_q  <= rsp_pending_d;
            rsp_port_q     <= rsp_port_d;
            err_q          <= err_d;
            addr_hold_q    <= addr_hold_d;
            din_hold_q     <= din_hold_d;
        end
    end

    // RAM read data is already registered, so both ports simply see mem_dout.
    assign rvalid0 = rsp_pending_q & ~rsp_port_q;
    assign rvalid1 = rsp_pending_q & rsp_port_q;
    assign rdata0  = mem_dout;
    assign rdata1  = mem_dout;
    assign err     = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, all checked against a
// transaction-level model of arbitration, memory contents and read responses.
module tb_dmem_arbiter;
    localparam int DATA_W     = 32;
    localparam int DEPTH_LOG2 = 5;

    logic clock  = 1'b0;
    logic resetn = 1'b0;
    logic req0, we0, lock0, req1, we1, lock1;
    logic [31:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1, rdata0, rdata1, mem_din, mem_dout;
    logic gnt0, gnt1, rvalid0, rvalid1, mem_we, err;
    logic [DEPTH_LOG2-1:0] mem_addr;

    always #5 clock = ~clock;

    dmem_arbiter #(.DATA_W(DATA_W), .DEPTH_LOG2(DEPTH_LOG2)) dut (
        .clock(clock), .resetn(resetn),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
        .err(err)
    );

    // RAM with one-cycle registered read
    logic [DATA_W-1:0] ram [32];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    int tests = 0;
    int fails = 0;

    // reference model state
    int          m_last;
    bit          m_locked;
    bit          m_pend;
    int          m_pport;
    logic [31:0] m_pdata;
    bit          m_err;
    logic [4:0]  m_hold_addr;
    logic [31:0] m_hold_din;
    bit          m_hold_known;
    logic [31:0] ref_mem [32];

    // observed values captured mid-cycle
    logic        s_gnt0, s_gnt1, s_mem_we, s_rvalid0, s_rvalid1, s_err;
    logic [4:0]  s_mem_addr;
    logic [31:0] s_mem_din, s_rdata0, s_rdata1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit q0, input bit w0, input bit l0, input logic [31:0] a0,
                         input logic [31:0] d0, input bit q1, input bit w1, input bit l1,
                         input logic [31:0] a1, input logic [31:0] d1);
        req0 = q0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
    endtask

    task automatic model_reset();
        m_last = 1; m_locked = 0; m_pend = 0; m_pport = 0; m_err = 0; m_hold_known = 0;
    endtask

    // One clock: check outputs mid-cycle against the model, advance the model, cross the edge.
    task automatic cycle();
        bit          rq[2], wr[2], lk[2];
        logic [31:0] ad[2], wd[2];
        logic [31:0] a;
        logic [4:0]  word;
        int          win;
        #4;
        s_gnt0 = gnt0; s_gnt1 = gnt1; s_mem_we = mem_we; s_mem_addr = mem_addr;
        s_mem_din = mem_din; s_rvalid0 = rvalid0; s_rvalid1 = rvalid1;
        s_rdata0 = rdata0; s_rdata1 = rdata1; s_err = err;
        if (!resetn) begin
            chk("rst_gnt0", 32'(s_gnt0), 32'd0);
            chk("rst_gnt1", 32'(s_gnt1), 32'd0);
            chk("rst_mem_we", 32'(s_mem_we), 32'd0);
            chk("rst_rvalid0", 32'(s_rvalid0), 32'd0);
            chk("rst_rvalid1", 32'(s_rvalid1), 32'd0);
            chk("rst_err", 32'(s_err), 32'd0);
            model_reset();
        end else begin
            rq[0] = req0; wr[0] = we0; lk[0] = lock0; ad[0] = addr0; wd[0] = wdata0;
            rq[1] = req1; wr[1] = we1; lk[1] = lock1; ad[1] = addr1; wd[1] = wdata1;
            if (rq[0] && rq[1]) begin
`ifdef DMEM_ARB_CPU_PRIO_EN
                win = 0;
`else
                win = (m_locked && lk[m_last]) ? m_last : 1 - m_last;
`endif
            end else if (rq[0]) win = 0;
            else if (rq[1]) win = 1;
            else win = -1;
            chk("gnt0", 32'(s_gnt0), 32'(win == 0));
            chk("gnt1", 32'(s_gnt1), 32'(win == 1));
            chk("rvalid0", 32'(s_rvalid0), 32'(m_pend && m_pport == 0));
            chk("rvalid1", 32'(s_rvalid1), 32'(m_pend && m_pport == 1));
            if (m_pend) chk("rdata", (m_pport == 0) ? s_rdata0 : s_rdata1, m_pdata);
            chk("err", 32'(s_err), 32'(m_err));
            if (win >= 0) begin
                a    = ad[win];
                word = a[DEPTH_LOG2+1:2];
                chk("mem_we", 32'(s_mem_we), 32'(wr[win]));
                chk("mem_addr", 32'(s_mem_addr), 32'(word));
                if (wr[win]) begin
                    chk("mem_din", s_mem_din, wd[win]);
                    ref_mem[word] = wd[win];
                end
                m_pend = !wr[win];
                m_pport = win;
                m_pdata = ref_mem[word];
                m_last = win;
                m_locked = lk[win];
                if (a[31:DEPTH_LOG2+2] != 0) m_err = 1;
                m_hold_addr = word;
                m_hold_din = wd[win];
                m_hold_known = 1;
            end else begin
                chk("idle_mem_we", 32'(s_mem_we), 32'd0);
                if (m_hold_known) begin
                    chk("hold_addr", 32'(s_mem_addr), 32'(m_hold_addr));
                    chk("hold_din", s_mem_din, m_hold_din);
                end
                m_pend = 0;
                if (!lk[m_last]) m_locked = 0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        bit          rq_r[2], we_r[2], lk_r[2], got[2];
        logic [31:0] ad_r[2], wd_r[2];
        logic [31:0] a;
        for (int i = 0; i < 32; i++) begin
            ram[i] = '0;
            ref_mem[i] = '0;
        end
        mem_dout = '0;
        model_reset();

        // reset, with a request present that must not be granted
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(1, 1, 0, 32'h8, 32'h1234, 1, 0, 0, 32'h4, 0);
        cycle();
        resetn = 1'b1;

        // write then read-back of the same word
        drive(1, 1, 0, 32'h8, 32'hDEADBEEF, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_gnt0", 32'(s_gnt0), 32'd1);
        chk("t1_we", 32'(s_mem_we), 32'd1);
        chk("t1_addr", 32'(s_mem_addr), 32'd2);
        drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h8, 0);
        cycle();
        chk("t1_gnt1", 32'(s_gnt1), 32'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t1_rvalid1", 32'(s_rvalid1), 32'd1);
        chk("t1_rdata1", s_rdata1, 32'hDEADBEEF);

        // both ports reading continuously
        drive(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'h10, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
`ifdef DMEM_ARB_CPU_PRIO_EN
            chk("t2_gnt0", 32'(s_gnt0), 32'd1);
`else
            chk("t2_alt", 32'(s_gnt1), 32'(i % 2));
`endif
            chk("t2_rv_excl", 32'(s_rvalid0 & s_rvalid1), 32'd0);
        end

        // locked port 0, then lock dropped while still contended
        drive(1, 0, 1, 32'h8, 0, 1, 0, 0, 32'h10, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("t3_lock_gnt0", 32'(s_gnt0), 32'd1);
        end
        drive(1, 0, 0, 32'h8, 0, 1, 0, 0, 32'h10, 0);
        cycle();
`ifdef DMEM_ARB_CPU_PRIO_EN
        chk("t3_prio_gnt0", 32'(s_gnt0), 32'd1);
`else
        chk("t3_unlock_gnt1", 32'(s_gnt1), 32'd1);
`endif

        // out-of-range address sets the sticky error
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 32'h80, 0);
        cycle();
        chk("t4_gnt1", 32'(s_gnt1), 32'd1);
        chk("t4_addr", 32'(s_mem_addr), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("t4_err", 32'(s_err), 32'd1);
        cycle();
        chk("t4_err_sticky", 32'(s_err), 32'd1);

        // reset right after a locked read grant to port 1
        drive(0, 0, 0, 0, 0, 1, 0, 1, 32'h4, 0);
        cycle();
        chk("t5_gnt1", 32'(s_gnt1), 32'd1);
        resetn = 1'b0;
        cycle();
        chk("t5_rvalid1", 32'(s_rvalid1), 32'd0);
        resetn = 1'b1;
        drive(1, 0, 0, 32'h4, 0, 1, 0, 1, 32'h4, 0);
        cycle();
        chk("t5_first_gnt0", 32'(s_gnt0), 32'd1);

`ifdef DMEM_ARB_CPU_PRIO_EN
        drive(1, 0, 0, 32'h0, 0, 1, 0, 0, 32'hC, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("t6_gnt0", 32'(s_gnt0), 32'd1);
            chk("t6_gnt1", 32'(s_gnt1), 32'd0);
        end
`endif

        // random traffic: requests held until granted
        for (int p = 0; p < 2; p++) begin
            rq_r[p] = 0;
            got[p] = 0;
        end
        for (int n = 0; n < 400; n++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq_r[p] || got[p]) begin
                    rq_r[p] = ($urandom_range(0, 3) != 0);
                    we_r[p] = ($urandom_range(0, 1) == 1);
                    lk_r[p] = ($urandom_range(0, 3) == 0);
                    a = {25'd0, 5'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
                    if ($urandom_range(0, 31) == 0) a[31:DEPTH_LOG2+2] = 25'($urandom_range(1, 4000));
                    ad_r[p] = a;
                    wd_r[p] = $urandom;
                end
            end
            drive(rq_r[0], we_r[0], lk_r[0], ad_r[0], wd_r[0],
                  rq_r[1], we_r[1], lk_r[1], ad_r[1], wd_r[1]);
            resetn = (n == 200) ? 1'b0 : 1'b1;
            cycle();
            got[0] = s_gnt0;
            got[1] = s_gnt1;
        end
        resetn = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        cycle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 32-word data RAM between two requesters:
  - Port 0: CPU load/store path.
  - Port 1: I/O or DMA engine.
- Sits between the requesters and the RAM wrapper.
- Drives RAM address, write data and write enable; routes registered read data back to the owning requester with a valid strobe.
- Round-robin arbitration with an optional atomic lock for read-modify-write.

Parameters:
- DATA_W, 32, data word width.
- DEPTH_LOG2, 5, RAM word-address width; word address is addr[DEPTH_LOG2+1:2].

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- resetn  in  1  asynchronous active-low reset.
- req0  in  1  port 0 request; held with we0/addr0/wdata0 stable until gnt0.
- we0  in  1  port 0 write (1) / read (0).
- lock0  in  1  port 0 keeps ownership after its current grant while asserted.
- addr0  in  32  port 0 byte address.
- wdata0  in  DATA_W  port 0 write data.
- gnt0  out  1  port 0 request accepted this cycle.
- rvalid0  out  1  port 0 read data valid.
- rdata0  out  DATA_W  port 0 read data.
- req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1: same as port 0, for port 1.
- mem_we  out  1  RAM write enable.
- mem_addr  out  DEPTH_LOG2  RAM word address.
- mem_din  out  DATA_W  RAM write data.
- mem_dout  in  DATA_W  RAM read data, valid one clock after the address is presented.
- err  out  1  sticky flag: a granted access had nonzero addr[31:DEPTH_LOG2+2].

Behaviour:
- Reset (resetn low, asynchronous):
  - last_grant=1, so port 0 wins the first contention.
  - owner_locked=0, rsp_pending=0, rsp_port=0.
  - rvalid0=rvalid1=0 and err=0.
  - gnt0=gnt1=0 while in reset.
- Grant decision (combinational, each cycle):
  - Only req0 → port 0. Only req1 → port 1.
  - Both → the port not equal to last_grant, unless owner_locked, in which case the locked owner wins.
  - Neither → no grant; mem_we=0 and mem_addr/mem_din hold their last selected values.
- gnt0/gnt1 are mutually exclusive; at most one grant per cycle.
- Access:
  - mem_addr, mem_din and mem_we = we_x are driven from the granted port in the grant cycle.
  - mem_we is never asserted without a grant.
- Registered updates on a granted cycle:
  - last_grant <= granted port.
  - owner_locked <= lock_x of the granted port.
  - rsp_pending <= ~we_x; rsp_port <= granted port.
  - If the granted address has any bit set in [31:DEPTH_LOG2+2], err <= 1; the access still proceeds using the low bits.
- Lock release: lock_x low, or the owner deasserts req while the other port requests, clears owner_locked next cycle. A locked owner with req low does not block the other port.
- Read response:
  - One cycle after a read grant, rvalid_x=1 for exactly one cycle on rsp_port.
  - rdata_x = mem_dout in that cycle; rdata of the non-responding port is undefined.
  - Writes produce no rvalid.
- Throughput: back-to-back grants every cycle; a new grant may coincide with the previous read's rvalid.
- Read-after-write to the same address on consecutive grants returns the new data.
- Reset mid-transaction: pending rvalid is dropped and the lock is cleared; no partial write (mem_we forced 0 during reset).

Optional Feature:
- Macro: DMEM_ARB_CPU_PRIO_EN.
- Defined: fixed priority. Port 0 always wins contention; lock1 is honoured only when req0=0. last_grant is still tracked but unused for the decision.
- Undefined: round-robin as specified above.

Test Plan:
- Reset, then req0 write addr0=0x08 wdata0=0xDEADBEEF; next cycle req1 read addr1=0x08 → gnt0 in cycle 1 with mem_we=1, mem_addr=2; gnt1 in cycle 2; rvalid1=1, rdata1=0xDEADBEEF in cycle 3.
- Both req0/req1 reads held for 4 cycles → grants alternate 0,1,0,1; rvalid alternates one cycle behind, never both high.
- lock0=1 with req0 and req1 both held 3 cycles → gnt0 for 3 consecutive cycles; drop lock0 → gnt1 on the next contended cycle.
- req1 read addr1=0x80 → err rises and stays 1; mem_addr=0.
- Assert resetn=0 in the cycle after a read grant → rvalid stays 0, lock clears; after release, port 0 wins the first contention.
- With DMEM_ARB_CPU_PRIO_EN defined, both ports request for 4 cycles → gnt0 all 4 cycles, gnt1 never.
